rtc_timekeeper: RTL and testbench

Free-running time-of-day counter that produces the packed 18-bit `{hour,min,sec}` current-time bus that the alarm block compares against. It is the source end of that bus. It divides the system clock down to a 1 Hz tick and advances seconds, minutes and hours with carries. It also provides a set mode in which pushbutton pulses adjust the time with the same carry semantics as the alarm-set keys. It sits between the board clock/keys and the alarm and display blocks.

---
 rtl/rtc_timekeeper.sv | 103 ++++++++++
 tb/tb_rtc_timekeeper.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timekeeper.sv
// Time-of-day counter: 1 Hz prescaler plus hour/min/sec fields with carries,
// and a set mode where key pulses step the time using the same carry chain.
module rtc_timekeeper #(
   parameter int unsigned TICK_DIV = 1000,
   parameter logic [1:0]  SET_MODE = 2'b10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode,
   input  logic        en,
   input  logic        hourkey,
   input  logic        minkey,
   input  logic        seckey,
   output logic [17:0] cur_clock,
   output logic        sec_tick,
   output logic        min_tick,
   output logic        hour_tick
);

   localparam int unsigned DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

   typedef enum logic [1:0] {OP_RUN, OP_HOLD, OP_SET} op_e;

   op_e           op;
   logic [5:0]    hour, min, sec;
   logic [5:0]    hour_n, min_n, sec_n;
   logic [DW-1:0] div, div_n;
   logic          run_adv;
   logic          adv_sec, adv_min, adv_hour;
   logic          sec_wrap, min_wrap;

   always_comb begin
      if (mode == SET_MODE) op = OP_SET;
      else if (en)          op = OP_RUN;
      else                  op = OP_HOLD;
   end

   assign sec_wrap = (sec == 6'd59);
   assign min_wrap = (min == 6'd59);

   // One carry chain serves both the prescaler advance and the set keys;
   // the key priority only decides which stage the chain is entered at.
   always_comb begin
      run_adv  = 1'b0;
      adv_sec  = 1'b0;
      adv_min  = 1'b0;
      adv_hour = 1'b0;
      div_n    = div;
      case (op)
         OP_RUN: begin
            if (div == DIV_LAST) begin
               div_n   = '0;
               run_adv = 1'b1;
               adv_sec = 1'b1;
            end else begin
               div_n = div + DW'(1);
            end
         end
         OP_SET: begin
            div_n = '0;
            if (seckey)       adv_sec  = 1'b1;
            else if (minkey)  adv_min  = 1'b1;
            else if (hourkey) adv_hour = 1'b1;
         end
         default: ;
      endcase
      if (adv_sec && sec_wrap) adv_min  = 1'b1;
      if (adv_min && min_wrap) adv_hour = 1'b1;
   end

   always_comb begin
      sec_n  = sec;
      min_n  = min;
      hour_n = hour;
      if (adv_sec)  sec_n  = sec_wrap ? '0 : sec + 6'd1;
      if (adv_min)  min_n  = min_wrap ? '0 : min + 6'd1;
      if (adv_hour) hour_n = (hour == 6'd23) ? '0 : hour + 6'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hour      <= '0;
         min       <= '0;
         sec       <= '0;
         div       <= '0;
         sec_tick  <= 1'b0;
         min_tick  <= 1'b0;
         hour_tick <= 1'b0;
      end else begin
         hour      <= hour_n;
         min       <= min_n;
         sec       <= sec_n;
         div       <= div_n;
         sec_tick  <= run_adv;
         min_tick  <= run_adv && sec_wrap;
         hour_tick <= run_adv && sec_wrap && min_wrap;
      end
   end

   assign cur_clock = {hour, min, sec};

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: directed scenarios plus random stimulus, checked
// against a seconds-of-day model.
module tb_rtc_timekeeper;

   localparam int unsigned TDIV = 4;
   localparam logic [1:0]  SETM = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic        en, hourkey, minkey, seckey;
   logic [17:0] cur_clock;
   logic        sec_tick, min_tick, hour_tick;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int t_day;
   int pdiv;
   bit m_st, m_mt, m_ht;
   bit prev_st;

   rtc_timekeeper #(.TICK_DIV(TDIV), .SET_MODE(SETM)) dut (
      .clk(clk), .rst(rst), .mode(mode), .en(en),
      .hourkey(hourkey), .minkey(minkey), .seckey(seckey),
      .cur_clock(cur_clock), .sec_tick(sec_tick),
      .min_tick(min_tick), .hour_tick(hour_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [17:0] hms(input int h, input int m, input int s);
      return {6'(h), 6'(m), 6'(s)};
   endfunction

   function automatic logic [17:0] pack_t(input int t);
      return hms(t / 3600, (t / 60) % 60, t % 60);
   endfunction

   task automatic model_reset();
      t_day = 0;
      pdiv  = 0;
      m_st  = 0;
      m_mt  = 0;
      m_ht  = 0;
   endtask

   task automatic model_edge();
      m_st = 0; m_mt = 0; m_ht = 0;
      if (rst) begin
         model_reset();
      end else if (mode == SETM) begin
         pdiv = 0;
         if (seckey)       t_day = (t_day + 1) % 86400;
         else if (minkey)  t_day = (t_day + 60) % 86400;
         else if (hourkey) t_day = (t_day / 3600 == 23) ? t_day - 23 * 3600 : t_day + 3600;
      end else if (en) begin
         if (pdiv == TDIV - 1) begin
            pdiv  = 0;
            t_day = (t_day + 1) % 86400;
            m_st  = 1;
            m_mt  = (t_day % 60 == 0);
            m_ht  = (t_day % 3600 == 0);
         end else begin
            pdiv++;
         end
      end
   endtask

   // Advance one clock edge and compare all outputs 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("cur_clock", 32'(cur_clock), 32'(pack_t(t_day)));
      check("sec_tick", 32'(sec_tick), 32'(m_st));
      check("min_tick", 32'(min_tick), 32'(m_mt));
      check("hour_tick", 32'(hour_tick), 32'(m_ht));
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("async_rst_clock", 32'(cur_clock), 32'd0);
      check("async_rst_ticks", 32'({sec_tick, min_tick, hour_tick}), 32'd0);
      step();
      rst = 1'b0;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      mode = SETM;
      hourkey = 1'b1;
      repeat (h) step();
      hourkey = 1'b0;
      minkey = 1'b1;
      repeat (m) step();
      minkey = 1'b0;
      seckey = 1'b1;
      repeat (s) step();
      seckey = 1'b0;
      check("set_time", 32'(cur_clock), 32'(hms(h, m, s)));
   endtask

   initial begin
      rst = 1'b1; mode = 2'b00; en = 1'b1;
      hourkey = 1'b0; minkey = 1'b0; seckey = 1'b0;
      model_reset();

      // reset and first tick
      step();
      step();
      rst = 1'b0;
      repeat (3) step();
      check("first_tick_early", 32'(sec_tick), 32'd0);
      step();
      check("first_tick", 32'(sec_tick), 32'd1);
      check("first_tick_time", 32'(cur_clock), 32'(hms(0, 0, 1)));
      repeat (12) step();

      // full-day wrap
      do_reset();
      set_time(23, 59, 59);
      mode = 2'b00;
      repeat (3) step();
      check("pre_wrap", 32'(cur_clock), 32'(hms(23, 59, 59)));
      step();
      check("wrap_time", 32'(cur_clock), 32'd0);
      check("wrap_ticks", 32'({sec_tick, min_tick, hour_tick}), 32'b111);
      step();
      check("wrap_ticks_off", 32'({sec_tick, min_tick, hour_tick}), 32'b000);

      // set-mode carries
      do_reset();
      set_time(0, 59, 59);
      seckey = 1'b1; step(); seckey = 1'b0;
      check("sec_carry", 32'(cur_clock), 32'(hms(1, 0, 0)));
      do_reset();
      set_time(0, 59, 0);
      minkey = 1'b1; step(); minkey = 1'b0;
      check("min_carry", 32'(cur_clock), 32'(hms(1, 0, 0)));
      do_reset();
      set_time(23, 10, 0);
      hourkey = 1'b1; step(); hourkey = 1'b0;
      check("hour_wrap", 32'(cur_clock), 32'(hms(0, 10, 0)));

      // key priority
      do_reset();
      set_time(5, 5, 5);
      seckey = 1'b1; minkey = 1'b1; hourkey = 1'b1;
      step();
      seckey = 1'b0; minkey = 1'b0; hourkey = 1'b0;
      check("key_priority", 32'(cur_clock), 32'(hms(5, 5, 6)));

      // hold and mode switch
      do_reset();
      mode = 2'b00; en = 1'b1;
      step(); step();
      en = 1'b0;
      repeat (10) step();
      check("hold_time", 32'(cur_clock), 32'd0);
      en = 1'b1;
      step();
      check("resume_no_tick", 32'(sec_tick), 32'd0);
      step();
      check("resume_tick", 32'(sec_tick), 32'd1);
      step(); step();
      mode = SETM;
      step();
      mode = 2'b01;
      repeat (3) step();
      check("after_set_no_tick", 32'(sec_tick), 32'd0);
      step();
      check("after_set_tick", 32'(sec_tick), 32'd1);
      check("after_set_time", 32'(cur_clock), 32'(hms(0, 0, 2)));
      seckey = 1'b1; minkey = 1'b1; hourkey = 1'b1;
      repeat (3) step();
      seckey = 1'b0; minkey = 1'b0; hourkey = 1'b0;
      check("keys_in_run", 32'(cur_clock), 32'(hms(0, 0, 2)));

      // asynchronous reset mid-cycle
      do_reset();

      // random stimulus
      prev_st = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         mode    = 2'($urandom_range(0, 3));
         en      = ($urandom % 8) != 0;
         seckey  = ($urandom % 4) == 0;
         minkey  = ($urandom % 4) == 0;
         hourkey = ($urandom % 4) == 0;
         step();
         check("hour_range", 32'(cur_clock[17:12] <= 6'd23), 32'd1);
         check("min_range", 32'(cur_clock[11:6] <= 6'd59), 32'd1);
         check("sec_range", 32'(cur_clock[5:0] <= 6'd59), 32'd1);
         check("tick_width", 32'(prev_st && sec_tick), 32'd0);
         prev_st = sec_tick;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
